// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access; MA has priority, IF gets one grant after MA_BURST_MAX MA grants.
// Grant takes effect one cycle after the IDLE decision; request/response paths are combinational pass-through.
// Requesters see mem_req_ready as their ready; response readiness passes back from the owner (or forced high to drain a cancelled fetch).
module mem_port_arbiter #(
    parameter int MA_BURST_MAX = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [31:0]       if_rdata,
    input  logic              if_cancel,
    input  logic              ma_req_valid,
    output logic              ma_req_ready,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic              ma_wen,
    input  logic [31:0]       ma_wdata,
    input  logic [3:0]        ma_wstrb,
    output logic              ma_resp_valid,
    input  logic              ma_resp_ready,
    output logic [31:0]       ma_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        IF_REQ,
        IF_RESP,
        MA_REQ,
        MA_RESP
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MA_BURST_MAX);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic       discard, discard_nxt;
    logic       if_drop;
    logic       resp_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            discard   <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            discard   <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        discard_nxt    = discard;
        if_drop        = 1'b0;
        resp_take      = 1'b0;
        if_req_ready   = 1'b0;
        if_resp_valid  = 1'b0;
        if_rdata       = '0;
        ma_req_ready   = 1'b0;
        ma_resp_valid  = 1'b0;
        ma_rdata       = '0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        mem_resp_ready = 1'b0;

        case (state)
            IDLE: begin
                // MA wins unless IF has already waited out a full MA burst
                if (ma_req_valid && (!if_req_valid || burst_cnt < BURST_MAX)) begin
                    state_nxt     = MA_REQ;
                    burst_cnt_nxt = if_req_valid ? burst_cnt + 4'd1 : 4'd0;
                end else if (if_req_valid) begin
                    state_nxt     = IF_REQ;
                    burst_cnt_nxt = 4'd0;
                end
            end
            IF_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = if_addr;
                if_req_ready  = mem_req_ready;
                if (if_cancel) begin
                    discard_nxt = 1'b1;
                end
                if (mem_req_ready) begin
                    state_nxt = IF_RESP;
                end
            end
            IF_RESP: begin
                // A cancelled fetch is still drained from memory, just never shown to IF
                if_drop        = discard | if_cancel;
                resp_take      = if_drop | if_resp_ready;
                if_resp_valid  = mem_resp_valid & ~if_drop;
                if_rdata       = mem_rdata;
                mem_resp_ready = resp_take;
                if (if_cancel) begin
                    discard_nxt = 1'b1;
                end
                if (mem_resp_valid && resp_take) begin
                    state_nxt   = IDLE;
                    discard_nxt = 1'b0;
                end
            end
            MA_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = ma_addr;
                mem_wen       = ma_wen;
                mem_wdata     = ma_wdata;
                mem_wstrb     = ma_wstrb;
                ma_req_ready  = mem_req_ready;
                if (mem_req_ready) begin
                    state_nxt = ma_wen ? IDLE : MA_RESP;
                end
            end
            MA_RESP: begin
                ma_resp_valid  = mem_resp_valid;
                ma_rdata       = mem_rdata;
                mem_resp_ready = ma_resp_ready;
                if (mem_resp_valid && ma_resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
